hamming_enc_arbiter: RTL and testbench
======================================

// Module: hamming_enc_arbiter
// PURPOSE
//  Shares one combinational Hamming(12,8) encoder between NUM_REQ byte requesters.
//  Round-robin arbitration picks one valid requester per cycle and encodes its byte.
//  The codeword is registered into a 1-deep output stage with a valid/ready handshake.
//  The output carries the source ID. Sits between byte producers and the codeword sink.
// PARAMETERS
//  NUM_REQ  2   number of requesters, 2..8
//  ID_W     $clog2(NUM_REQ) (min 1)   width of cw_src
//  CNT_W    16  width of the accepted-codeword counter
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  enable     in   1           0 = issue no new grants; the output stage still drains
//  req_valid  in   NUM_REQ     per-requester byte valid
//  req_ready  out  NUM_REQ     per-requester accept, one-hot or zero
//  req_data   in   NUM_REQ*8   byte of requester i in [8*i+7:8*i]
//  cw_valid   out  1           output codeword valid
//  cw_ready   in   1           sink accepts codeword
//  cw_data    out  12          encoded codeword
//  cw_src     out  ID_W        index of the requester that produced cw_data
//  cw_count   out  CNT_W       codewords accepted by the sink (cw_valid & cw_ready)
// BEHAVIOUR
//  Reset values (sync, rst=1 at posedge): cw_valid=0, cw_data=0, cw_src=0, cw_count=0.
//   Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
//  Stage advance: adv = enable & (~cw_valid | cw_ready).
//  Grant: if adv, grant = first i with req_valid[i]=1.
//   Search order: last_grant+1, last_grant+2, ... wrapping mod NUM_REQ.
//   req_ready = onehot(grant) only when adv and a grant exists; otherwise req_ready=0.
//   req_ready depends combinationally on req_valid, enable and cw_ready.
//   There is no combinational path from req_data to any output.
//  Transfer: req_valid[i] & req_ready[i]. At the next edge:
//   cw_data <= enc(req_data[i]); cw_src <= i; cw_valid <= 1; last_grant <= i.
//  Encoder mapping, cw[11:0]:
//   cw[11:8]=d[7:4]; cw[6:4]=d[3:1]; cw[2]=d[0]
//   cw[0]=cw10^cw8^cw6^cw4^cw2; cw[1]=cw10^cw9^cw6^cw5^cw2
//   cw[3]=cw11^cw6^cw5^cw4; cw[7]=cw11^cw10^cw9^cw8
//  Latency: 1 cycle from req transfer to cw_valid.
//   Full throughput: 1 codeword/cycle while cw_ready=1.
//  Output hold: while cw_valid & ~cw_ready, cw_data/cw_src are stable and req_ready=0.
//  Sink accept with no new grant: cw_valid <= 0. Accept and new grant in the same cycle: reload, cw_valid stays 1.
//  enable=0: no grant. A pending codeword still completes on cw_ready; last_grant is unchanged.
//  No valid requester: last_grant is unchanged.
//  Counter: cw_count increments on each cw_valid & cw_ready and wraps at 2^CNT_W-1 -> 0.
//  Reset mid-operation: a pending codeword is discarded, the pointer returns to reset, no handshake completes.
//  The block never drops or duplicates a granted byte; requesters must hold req_data while req_valid & ~req_ready.
// STRUCTURE
//  Sub-module hamming (8->12 combinational encoder): one instance, input muxed by grant.
//  Round-robin pick: a function or generate loop local to this file.
//  Shared package (hamming_pkg): CW_W=12, DATA_W=8, parity-position constants P0=0,P1=1,P3=3,P7=7.
// TESTING
//  1 Reset, NUM_REQ=2, req0 sends 0xFF, cw_ready=1.
//    -> req_ready=2'b01; next cycle cw_valid=1, cw_data=0xF77, cw_src=0, then cw_count=1.
//  2 Encoder values, single requester: 0x00->0x000, 0x01->0x007, 0x80->0x888, 0xFF->0xF77.
//  3 Both requesters valid continuously, cw_ready=1.
//    -> grants alternate 0,1,0,1; cw_src alternates; 1 codeword per cycle.
//  4 cw_ready=0 for 3 cycles with a pending word.
//    -> cw_data/cw_src stable, req_ready=0; after cw_ready=1, the next grant goes to the other requester.
//  5 enable=0 with req_valid=2'b11 -> req_ready=0; the pending word still drains; after enable=1, grants resume from last_grant+1.
//  6 rst=1 while cw_valid=1 -> next cycle cw_valid=0, cw_count=0, first grant to req0.
//    Preload: cw_count=0xFFFF + one accept -> 0x0000.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming(12,8) encoder.
package hamming_pkg;

   localparam int CW_W   = 12;
   localparam int DATA_W = 8;

   localparam int P0 = 0;
   localparam int P1 = 1;
   localparam int P3 = 3;
   localparam int P7 = 7;

   // Coverage masks: each parity bit is the XOR of the data positions set here.
   localparam logic [CW_W-1:0] M_P0 = 12'h554;
   localparam logic [CW_W-1:0] M_P1 = 12'h664;
   localparam logic [CW_W-1:0] M_P3 = 12'h870;
   localparam logic [CW_W-1:0] M_P7 = 12'hF00;

   function automatic logic [CW_W-1:0] hamming_place(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] cw;
      cw        = '0;
      cw[11:8]  = d[7:4];
      cw[6:4]   = d[3:1];
      cw[2]     = d[0];
      return cw;
   endfunction

   function automatic logic hamming_parity(input logic [CW_W-1:0] cw,
                                           input logic [CW_W-1:0] mask);
      return ^(cw & mask);
   endfunction

endpackage

// File: rtl/hamming.sv
// Combinational 8->12 Hamming encoder.
module hamming
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CW_W-1:0]   cw_o
);

   logic [CW_W-1:0] placed_s;
   logic [CW_W-1:0] cw_s;

   // Place data bits, then fill the parity positions.
   always_comb begin
      placed_s  = hamming_place(data_i);
      cw_s      = placed_s;
      cw_s[P0]  = hamming_parity(placed_s, M_P0);
      cw_s[P1]  = hamming_parity(placed_s, M_P1);
      cw_s[P3]  = hamming_parity(placed_s, M_P3);
      cw_s[P7]  = hamming_parity(placed_s, M_P7);
   end

   assign cw_o = cw_s;

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter sharing one Hamming(12,8) encoder, with a 1-deep
// registered valid/ready output stage carrying the source index.
module hamming_enc_arbiter
   import hamming_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      cw_valid,
   input  logic                      cw_ready,
   output logic [CW_W-1:0]           cw_data,
   output logic [ID_W-1:0]           cw_src,
   output logic [CNT_W-1:0]          cw_count
);

   logic                 cw_valid_q,   cw_valid_d;
   logic [CW_W-1:0]      cw_data_q,    cw_data_d;
   logic [ID_W-1:0]      cw_src_q,     cw_src_d;
   logic [CNT_W-1:0]     cw_count_q,   cw_count_d;
   logic [ID_W-1:0]      last_grant_q, last_grant_d;

   logic                 adv_s;
   logic                 grant_found_s;
   logic [ID_W-1:0]      grant_idx_s;
   logic                 xfer_s;
   logic                 accept_s;
   logic [NUM_REQ-1:0]   req_ready_s;
   logic [DATA_W-1:0]    sel_data_s;
   logic [CW_W-1:0]      enc_cw_s;

   // Returns {found, index} of the first valid requester after 'last'.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [ID_W-1:0]    last);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!res[ID_W] && valid[idx]) begin
            res = {1'b1, ID_W'(idx)};
         end
      end
      return res;
   endfunction

   // Arbitration, handshake decode and encoder input mux.
   always_comb begin
      adv_s                        = enable & (~cw_valid_q | cw_ready);
      {grant_found_s, grant_idx_s} = rr_pick(req_valid, last_grant_q);
      xfer_s                       = adv_s & grant_found_s;
      accept_s                     = cw_valid_q & cw_ready;
      req_ready_s                  = '0;
      sel_data_s                   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_s == ID_W'(i)) begin
            req_ready_s[i] = xfer_s;
            sel_data_s     = req_data[DATA_W*i +: DATA_W];
         end else begin
            req_ready_s[i] = 1'b0;
         end
      end
   end

   hamming u_hamming (
      .data_i (sel_data_s),
      .cw_o   (enc_cw_s)
   );

   // Next-state of the output stage, pointer and counter.
   always_comb begin
      cw_valid_d   = cw_valid_q;
      cw_data_d    = cw_data_q;
      cw_src_d     = cw_src_q;
      last_grant_d = last_grant_q;
      cw_count_d   = cw_count_q;
      if (xfer_s) begin
         cw_valid_d   = 1'b1;
         cw_data_d    = enc_cw_s;
         cw_src_d     = grant_idx_s;
         last_grant_d = grant_idx_s;
      end else if (accept_s) begin
         cw_valid_d   = 1'b0;
      end else begin
         cw_valid_d   = cw_valid_q;
      end
      if (accept_s) begin
         cw_count_d = cw_count_q + CNT_W'(1);
      end else begin
         cw_count_d = cw_count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_valid_q   <= 1'b0;
         cw_data_q    <= '0;
         cw_src_q     <= '0;
         cw_count_q   <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         cw_valid_q   <= cw_valid_d;
         cw_data_q    <= cw_data_d;
         cw_src_q     <= cw_src_d;
         cw_count_q   <= cw_count_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign req_ready = req_ready_s;
   assign cw_valid  = cw_valid_q;
   assign cw_data   = cw_data_q;
   assign cw_src    = cw_src_q;
   assign cw_count  = cw_count_q;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Scoreboard bench: predicted codewords are queued on every transfer and
// popped/compared on every sink accept; scenario tasks check the rest inline.
module tb_hamming_enc_arbiter;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_data;
   logic        cw_valid;
   logic        cw_ready;
   logic [11:0] cw_data;
   logic [0:0]  cw_src;
   logic [15:0] cw_count;

   int checks = 0;
   int errors = 0;
   logic [12:0] sb_q[$];

   hamming_enc_arbiter #(.NUM_REQ(2), .ID_W(1), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .cw_valid  (cw_valid),
      .cw_ready  (cw_ready),
      .cw_data   (cw_data),
      .cw_src    (cw_src),
      .cw_count  (cw_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] model_enc(input logic [7:0] d);
      logic [11:0] c;
      c       = 12'h000;
      c[11:8] = d[7:4];
      c[6:4]  = d[3:1];
      c[2]    = d[0];
      c[0]    = c[10] ^ c[8] ^ c[6] ^ c[4] ^ c[2];
      c[1]    = c[10] ^ c[9] ^ c[6] ^ c[5] ^ c[2];
      c[3]    = c[11] ^ c[6] ^ c[5] ^ c[4];
      c[7]    = c[11] ^ c[10] ^ c[9] ^ c[8];
      return c;
   endfunction

   // Monitor: pop on accept, push model prediction on transfer, mid-cycle.
   always @(negedge clk) begin
      logic [12:0] exp_e;
      if (rst) begin
         sb_q.delete();
      end else begin
         if (cw_valid && cw_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got src=%0d cw=%03h, expected no codeword", cw_src, cw_data);
            end else begin
               exp_e = sb_q.pop_front();
               if ({cw_src, cw_data} !== exp_e) begin
                  errors++;
                  $display("FAIL sb_codeword: got src=%0d cw=%03h, expected src=%0d cw=%03h",
                           cw_src, cw_data, exp_e[12], exp_e[11:0]);
               end
            end
         end
         checks++;
         if ((req_ready & (req_ready - 2'd1)) != 2'b00 || (req_ready & ~req_valid) != 2'b00) begin
            errors++;
            $display("FAIL ready_legal: got req_ready=%b with req_valid=%b, expected one-hot-or-zero on valid", req_ready, req_valid);
         end
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb_q.push_back({i[0], model_enc(req_data[8*i +: 8])});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; req_valid = 2'b00; req_data = 16'h0000; cw_ready = 1'b1;
      step(); step();
      checks++;
      if ({cw_valid, cw_data, cw_src, cw_count} !== 30'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b d=%03h s=%0d n=%0d, expected all zero", cw_valid, cw_data, cw_src, cw_count);
      end
      rst = 1'b0; req_valid = 2'b01; req_data = 16'h00FF;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_grant: got %b, expected 01", req_ready);
      end
      step();
      req_valid = 2'b00;
      #1;
      checks++;
      if (cw_valid !== 1'b1 || cw_data !== 12'hF77 || cw_src !== 1'b0 || cw_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_first_cw: got v=%b d=%03h s=%0d n=%0d, expected 1 F77 0 0", cw_valid, cw_data, cw_src, cw_count);
      end
      step();
      checks++;
      if (cw_count !== 16'd1 || cw_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_count: got n=%0d v=%b, expected 1 0", cw_count, cw_valid);
      end
   endtask

   task automatic test_encoder();
      logic [7:0]  din [4]  = '{8'h00, 8'h01, 8'h80, 8'hFF};
      logic [11:0] dexp [4] = '{12'h000, 12'h007, 12'h888, 12'hF77};
      for (int k = 0; k < 4; k++) begin
         req_valid = 2'b01; req_data = {8'h00, din[k]};
         step();
         req_valid = 2'b00;
         #1;
         checks++;
         if (cw_data !== dexp[k] || cw_valid !== 1'b1) begin
            errors++;
            $display("FAIL enc_value: in=%02h got cw=%03h v=%b, expected %03h 1", din[k], cw_data, cw_valid, dexp[k]);
         end
      end
      for (int k = 0; k < 8; k++) begin
         req_valid = 2'b01; req_data = {8'h00, 8'($urandom_range(0, 255))};
         step();
      end
      req_valid = 2'b00;
      step(); step();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rdy;
      logic       rr_last = 1'b0;
      for (int k = 0; k < 8; k++) begin
         req_valid = 2'b11; req_data = 16'($urandom_range(0, 65535));
         #1;
         exp_rdy = rr_last ? 2'b01 : 2'b10;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rr_grant: cycle %0d got %b, expected %b", k, req_ready, exp_rdy);
         end
         rr_last = ~rr_last;
         step();
         checks++;
         if (cw_valid !== 1'b1 || cw_src !== rr_last) begin
            errors++;
            $display("FAIL rr_src: cycle %0d got v=%b s=%0d, expected 1 %0d", k, cw_valid, cw_src, rr_last);
         end
      end
      req_valid = 2'b00;
      step(); step();
   endtask

   task automatic test_backpressure();
      logic [11:0] held;
      req_valid = 2'b01; req_data = 16'h005A; cw_ready = 1'b0;
      held = model_enc(8'h5A);
      step();
      req_valid = 2'b11; req_data = 16'hC3A5;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== 2'b00 || cw_valid !== 1'b1 || cw_data !== held || cw_src !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d got r=%b v=%b d=%03h s=%0d, expected 00 1 %03h 0",
                     k, req_ready, cw_valid, cw_data, cw_src, held);
         end
         step();
      end
      cw_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL bp_next_grant: got %b, expected 10", req_ready);
      end
      step();
      checks++;
      if (cw_src !== 1'b1 || cw_data !== model_enc(8'hC3)) begin
         errors++;
         $display("FAIL bp_next_cw: got s=%0d d=%03h, expected 1 %03h", cw_src, cw_data, model_enc(8'hC3));
      end
   endtask

   task automatic test_enable();
      logic [15:0] n0;
      n0 = cw_count;
      enable = 1'b0; req_valid = 2'b11; req_data = 16'h1234;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL en_no_grant: got %b, expected 00", req_ready);
      end
      step(); step();
      checks++;
      if (cw_valid !== 1'b0 || req_ready !== 2'b00 || cw_count !== n0 + 16'd1) begin
         errors++;
         $display("FAIL en_drain: got v=%b r=%b n=%0d, expected 0 00 %0d", cw_valid, req_ready, cw_count, n0 + 16'd1);
      end
      enable = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL en_resume: got %b, expected 01", req_ready);
      end
      step();
      req_valid = 2'b00;
      #1;
      checks++;
      if (cw_src !== 1'b0 || cw_data !== model_enc(8'h34)) begin
         errors++;
         $display("FAIL en_resume_cw: got s=%0d d=%03h, expected 0 %03h", cw_src, cw_data, model_enc(8'h34));
      end
      step();
   endtask

   task automatic test_reset_mid();
      req_valid = 2'b10; req_data = 16'h7700; cw_ready = 1'b0;
      step();
      req_valid = 2'b00; rst = 1'b1;
      step();
      rst = 1'b0; req_valid = 2'b11; cw_ready = 1'b1;
      #1;
      checks++;
      if (cw_valid !== 1'b0 || cw_count !== 16'd0 || req_ready !== 2'b01) begin
         errors++;
         $display("FAIL mid_reset: got v=%b n=%0d r=%b, expected 0 0 01", cw_valid, cw_count, req_ready);
      end
      step();
      req_valid = 2'b00;
      step();
   endtask

   task automatic test_count_wrap();
      rst = 1'b1;
      step();
      rst = 1'b0; req_valid = 2'b01; cw_ready = 1'b1;
      for (int k = 0; k < 65535; k++) begin
         req_data = {8'h00, k[7:0]};
         step();
      end
      req_valid = 2'b00;
      step();
      checks++;
      if (cw_count !== 16'hFFFF || cw_valid !== 1'b0) begin
         errors++;
         $display("FAIL cnt_max: got n=%04h v=%b, expected FFFF 0", cw_count, cw_valid);
      end
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      checks++;
      if (cw_count !== 16'h0000) begin
         errors++;
         $display("FAIL cnt_wrap: got %04h, expected 0000", cw_count);
      end
   endtask

   initial begin
      test_reset();
      test_encoder();
      test_round_robin();
      test_backpressure();
      test_enable();
      test_reset_mid();
      test_count_wrap();
      step();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
